// File: rtl/procedural_pipe.sv
// procedural_pipe: three-stage pipelined (a+b)*MULT / shift-mix / select datapath with overflow flag.
// Latency: 3 cycles from input handshake to out_valid when out_ready is held high; 1 beat/cycle sustained.
// Backpressure: valid/ready on both sides; in_ready is combinational from out_ready, pipe holds 3 beats.
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   in_valid/in_ready   operand handshake for a, b, sel
//   out_valid/out_ready result handshake for res1, res2, ovf
//   txn_count           completed output handshakes, wrapping at 2^CNT_W
module procedural_pipe #(
  parameter int WIDTH   = 16,
  parameter int MULT    = 10,
  parameter int SHIFT_A = 2,
  parameter int SHIFT_B = 3,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res1,
  output logic [WIDTH-1:0] res2,
  output logic             ovf,
  output logic [CNT_W-1:0] txn_count
);

  // Full-precision product width: (WIDTH+1)-bit sum times a WIDTH-bit constant.
  localparam int PW = 2 * WIDTH + 1;

  logic v1, v2, v3;
  logic load1, load2, load3;

  // A stage loads when it is empty or its contents move on this cycle,
  // so bubbles collapse and a full pipe still streams at one beat per cycle.
  assign load3     = !v3 || out_ready;
  assign load2     = !v2 || load3;
  assign load1     = !v1 || load2;
  assign in_ready  = load1;
  assign out_valid = v3;

  // ---------------- S1: sum, multiply, overflow detect ----------------
  logic [WIDTH:0]   sum;
  logic [PW-1:0]    prod;
  logic [WIDTH-1:0] s1_t1, s1_a, s1_b;
  logic             s1_sel, s1_ovf;

  assign sum  = {1'b0, a} + {1'b0, b};
  assign prod = PW'(sum) * PW'(MULT);

  always_ff @(posedge clk) begin
    if (rst) begin
      v1     <= 1'b0;
      s1_t1  <= '0;
      s1_a   <= '0;
      s1_b   <= '0;
      s1_sel <= 1'b0;
      s1_ovf <= 1'b0;
    end else if (load1) begin
      v1 <= in_valid;
      // Data only captured for real beats so an idle input never disturbs held values.
      if (in_valid) begin
        s1_t1  <= prod[WIDTH-1:0];
        s1_ovf <= |prod[PW-1:WIDTH];
        s1_a   <= a;
        s1_b   <= b;
        s1_sel <= sel;
      end
    end
  end

  // ---------------- S2: shift-mix ----------------
  logic [WIDTH-1:0] s1_shr, s1_shl, t2_next;
  logic [WIDTH-1:0] s2_t1, s2_t2, s2_a, s2_b;
  logic             s2_sel, s2_ovf;

  assign s1_shr  = s1_a >> SHIFT_A;
  assign s1_shl  = s1_b << SHIFT_B;   // bits shifted past WIDTH are dropped
  assign t2_next = s1_sel ? (s1_t1 ^ s1_shr) : (s1_t1 | s1_shl);

  always_ff @(posedge clk) begin
    if (rst) begin
      v2     <= 1'b0;
      s2_t1  <= '0;
      s2_t2  <= '0;
      s2_a   <= '0;
      s2_b   <= '0;
      s2_sel <= 1'b0;
      s2_ovf <= 1'b0;
    end else if (load2) begin
      v2 <= v1;
      if (v1) begin
        s2_t1  <= s1_t1;
        s2_t2  <= t2_next;
        s2_a   <= s1_a;
        s2_b   <= s1_b;
        s2_sel <= s1_sel;
        s2_ovf <= s1_ovf;
      end
    end
  end

  // ---------------- S3: result select, output registers ----------------
  logic [WIDTH-1:0] res1_next, res2_next;

  assign res1_next = s2_sel ? (s2_t2 & s2_b) : (s2_t2 + s2_a);
  assign res2_next = s2_t1 - s2_t2;

  always_ff @(posedge clk) begin
    if (rst) begin
      v3   <= 1'b0;
      res1 <= '0;
      res2 <= '0;
      ovf  <= 1'b0;
    end else if (load3) begin
      v3 <= v2;
      if (v2) begin
        res1 <= res1_next;
        res2 <= res2_next;
        ovf  <= s2_ovf;
      end
    end
  end

  // ---------------- completed-transaction counter ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      txn_count <= '0;
    end else if (v3 && out_ready) begin
      txn_count <= txn_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_procedural_pipe.sv
// tb_procedural_pipe: scoreboard bench for procedural_pipe.
// Latency: n/a (bench); drives beats from a stimulus queue, checks outputs in a separate monitor.
// Backpressure: out_ready is driven directly or randomised to exercise stalls.
module tb_procedural_pipe;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a, b;
  logic        sel;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] res1, res2;
  logic        ovf;
  logic [7:0]  txn_count;

  // second instance with a 2-bit counter to observe wrap-around
  logic        c2_in_ready, c2_out_valid, c2_ovf;
  logic [15:0] c2_res1, c2_res2;
  logic [1:0]  c2_txn;

  procedural_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sel(sel), .out_valid(out_valid), .out_ready(out_ready),
    .res1(res1), .res2(res2), .ovf(ovf), .txn_count(txn_count)
  );

  procedural_pipe #(.CNT_W(2)) dut_c2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(c2_in_ready),
    .a(a), .b(b), .sel(sel), .out_valid(c2_out_valid), .out_ready(out_ready),
    .res1(c2_res1), .res2(c2_res2), .ovf(c2_ovf), .txn_count(c2_txn)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        sel;
    logic        has_exp;
    logic [15:0] r1;
    logic [15:0] r2;
    logic        ovf;
  } stim_t;

  typedef struct {
    logic [15:0] r1;
    logic [15:0] r2;
    logic        ovf;
    int          cyc;
  } exp_t;

  stim_t stim_q[$];
  exp_t  exp_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cnt = 0;
  int n_hs = 0;
  logic lat_chk = 1'b0;
  logic rand_vld = 1'b0;
  logic rand_rdy = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Reference model: integer arithmetic at 32 bits, truncated where the datapath wraps.
  function automatic exp_t model(input logic [15:0] ma, input logic [15:0] mb, input logic ms, input int c);
    int unsigned p;
    logic [15:0] t1, t2, shr, shl;
    exp_t e;
    p     = (int'(ma) + int'(mb)) * 10;
    e.ovf = (p >= 32'd65536);
    t1    = p[15:0];
    shr   = ma >> 2;
    shl   = mb << 3;
    t2    = ms ? (t1 ^ shr) : (t1 | shl);
    e.r1  = ms ? (t2 & mb) : (t2 + ma);
    e.r2  = t1 - t2;
    e.cyc = c;
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, want);
    end
  endtask

  task automatic push_dir(input logic [15:0] pa, input logic [15:0] pb, input logic ps,
                          input logic [15:0] r1, input logic [15:0] r2, input logic po);
    stim_t s;
    s.a = pa; s.b = pb; s.sel = ps; s.has_exp = 1'b1; s.r1 = r1; s.r2 = r2; s.ovf = po;
    stim_q.push_back(s);
  endtask

  task automatic push_mod(input logic [15:0] pa, input logic [15:0] pb, input logic ps);
    stim_t s;
    s.a = pa; s.b = pb; s.sel = ps; s.has_exp = 1'b0; s.r1 = '0; s.r2 = '0; s.ovf = 1'b0;
    stim_q.push_back(s);
  endtask

  task automatic drain(input string nm);
    int k;
    k = 0;
    while ((stim_q.size() != 0 || exp_q.size() != 0) && k < 4000) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (k >= 4000) begin
      errors++;
      $display("FAIL %s_timeout: got %0d pending expected 0", nm, exp_q.size() + stim_q.size());
    end
    repeat (4) @(negedge clk);
  endtask

  // Driver: presents the head of stim_q, holds it until accepted.
  initial begin
    logic taken;
    exp_t e;
    taken = 1'b0;
    in_valid = 1'b0; a = '0; b = '0; sel = 1'b0;
    forever begin
      @(negedge clk);
      if (taken) in_valid = 1'b0;
      taken = 1'b0;
      if (!in_valid && stim_q.size() != 0 && (!rand_vld || $urandom_range(0, 2) != 0)) begin
        in_valid = 1'b1;
        a   = stim_q[0].a;
        b   = stim_q[0].b;
        sel = stim_q[0].sel;
      end
      #4;
      if (!rst && in_valid && in_ready) begin
        if (stim_q[0].has_exp) begin
          e.r1 = stim_q[0].r1; e.r2 = stim_q[0].r2; e.ovf = stim_q[0].ovf; e.cyc = cyc;
        end else begin
          e = model(a, b, sel, cyc);
        end
        exp_q.push_back(e);
        void'(stim_q.pop_front());
        acc_cnt++;
        taken = 1'b1;
      end
    end
  end

  // Randomised downstream readiness.
  initial forever begin
    @(negedge clk);
    if (rand_rdy) out_ready = ($urandom_range(0, 1) == 1);
  end

  // Monitor: pops the scoreboard on every output handshake.
  initial begin
    logic held;
    logic [32:0] hold_v;
    exp_t e;
    held = 1'b0;
    hold_v = '0;
    forever begin
      @(negedge clk);
      #4;
      if (rst) begin
        held = 1'b0;
        continue;
      end
      if (out_valid) begin
        if (held) chk("stall_hold", {res1, res2, ovf}, hold_v);
        if (out_ready) begin
          chk("txn_count", txn_count, n_hs[7:0]);
          chk("txn_count_w2", c2_txn, n_hs[1:0]);
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_out: got res1=%h res2=%h expected no beat", res1, res2);
          end else begin
            e = exp_q.pop_front();
            chk("res1", res1, e.r1);
            chk("res2", res2, e.r2);
            chk("ovf", ovf, e.ovf);
            if (lat_chk) chk("latency", cyc - e.cyc, 3);
          end
          n_hs++;
          held = 1'b0;
        end else begin
          held = 1'b1;
          hold_v = {res1, res2, ovf};
        end
      end else begin
        held = 1'b0;
      end
    end
  end

  initial begin
    int base;
    int k;
    rst = 1'b1;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #4;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_res1", res1, 0);
    chk("rst_res2", res2, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_txn", txn_count, 0);
    chk("rst_txn_w2", c2_txn, 0);

    // directed vectors with latency check
    lat_chk = 1'b1;
    push_dir(16'd12, 16'd6, 1'b1, 16'h0006, 16'hFFFD, 1'b0);
    push_dir(16'd12, 16'd6, 1'b0, 16'h00C0, 16'h0000, 1'b0);
    push_dir(16'hFFFF, 16'h0001, 1'b0, 16'h0007, 16'hFFF8, 1'b1);
    drain("directed");

    // backpressure: pipe fills to 3, then drains one per cycle
    lat_chk = 1'b0;
    @(negedge clk);
    out_ready = 1'b0;
    base = acc_cnt;
    push_dir(16'd12, 16'd6, 1'b1, 16'h0006, 16'hFFFD, 1'b0);
    push_dir(16'd12, 16'd6, 1'b0, 16'h00C0, 16'h0000, 1'b0);
    push_dir(16'hFFFF, 16'h0001, 1'b0, 16'h0007, 16'hFFF8, 1'b1);
    push_mod(16'h1234, 16'h00FF, 1'b1);
    push_mod(16'h8000, 16'h8000, 1'b0);
    repeat (8) @(negedge clk);
    chk("full_accepted", acc_cnt - base, 3);
    chk("full_in_ready", in_ready, 0);
    base = n_hs;
    out_ready = 1'b1;
    repeat (5) @(negedge clk);
    chk("drain_rate", n_hs - base, 5);
    drain("backpressure");

    // reset with two beats in flight
    out_ready = 1'b0;
    base = acc_cnt;
    push_mod(16'h0101, 16'h0202, 1'b1);
    push_mod(16'h0303, 16'h0404, 1'b0);
    k = 0;
    while (acc_cnt < base + 2 && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("inflight_accepted", acc_cnt - base, 2);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    stim_q.delete();
    n_hs = 0;
    @(negedge clk);
    rst = 1'b0;
    #4;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_txn", txn_count, 0);
    chk("midrst_in_ready", in_ready, 1);
    @(negedge clk);
    out_ready = 1'b1;
    lat_chk = 1'b1;
    push_dir(16'd12, 16'd6, 1'b1, 16'h0006, 16'hFFFD, 1'b0);
    drain("post_reset");

    // random traffic with random stalls on both sides
    lat_chk = 1'b0;
    rand_vld = 1'b1;
    rand_rdy = 1'b1;
    for (int i = 0; i < 300; i++)
      push_mod(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
    drain("random");
    rand_rdy = 1'b0;
    rand_vld = 1'b0;
    @(negedge clk);
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #4;
    chk("final_txn", txn_count, n_hs[7:0]);
    chk("final_txn_w2", c2_txn, n_hs[1:0]);
    chk("final_idle", out_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard stop in case anything above stalls.
  initial begin
    #400000;
    $display("FAIL global_timeout: got time %0t expected completion", $time);
    $fatal(1, "timeout");
  end

endmodule
